// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - instruction FIFO, IR, issue FSM and field decoder ahead of stateMachine
// Optional ILLEGAL_DROP_EN: illegal head entries are dropped and flagged instead of issued.
module instr_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic                     in_ready,
  input  logic                     w,
  input  logic [2:0]               nsel,
  output logic                     s,
  output logic [2:0]               opcode,
  output logic [1:0]               op,
  output logic [1:0]               ALUop,
  output logic [1:0]               shift,
  output logic [2:0]               readnum,
  output logic [2:0]               writenum,
  output logic [15:0]              sximm5,
  output logic [15:0]              sximm8,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     head;
  logic            push;
  logic            pop;
  logic            head_legal;

  assign head     = mem_q[rd_ptr_q];
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;

`ifdef ILLEGAL_DROP_EN
  logic illegal_q, illegal_d;

  // opcode 101 with any op, or opcode 110 with op 00/10 (op[0] clear)
  assign head_legal = (head[15:13] == 3'b101) ||
                      ((head[15:13] == 3'b110) && (head[11] == 1'b0));
  assign illegal    = illegal_q;
`else
  assign head_legal = 1'b1;
  assign illegal    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pop      = 1'b0;
`ifdef ILLEGAL_DROP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (w && (count_q != '0)) begin
          pop = 1'b1;
          if (head_legal) begin
            ir_d    = head;
            state_d = ISSUE;
          end else begin
`ifdef ILLEGAL_DROP_EN
            illegal_d = 1'b1;
`endif
          end
        end
      end
      ISSUE: state_d = RUN;
      RUN: begin
        if (w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ir_q     <= 16'h0000;
      mem_q    <= '{default: 16'h0000};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef ILLEGAL_DROP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef ILLEGAL_DROP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign s      = (state_q == ISSUE);
  assign count  = count_q;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign ALUop  = ir_q[12:11];
  assign shift  = ir_q[4:3];
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    unique case (nsel)
      3'b100:  readnum = ir_q[10:8];
      3'b010:  readnum = ir_q[7:5];
      3'b001:  readnum = ir_q[2:0];
      default: readnum = 3'b000;
    endcase
  end

  assign writenum = readnum;

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - directed self-checking bench for instr_issue_queue
module tb_instr_issue_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        w;
  logic [2:0]  nsel;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [2:0]  count;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  logic [15:0] words [5];

  instr_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w(w), .nsel(nsel), .s(s), .opcode(opcode),
    .op(op), .ALUop(ALUop), .shift(shift), .readnum(readnum),
    .writenum(writenum), .sximm5(sximm5), .sximm8(sximm8),
    .count(count), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Rebuilds the IR from decoded outputs; valid while nsel selects Rn.
  function automatic logic [15:0] ir_view();
    return {opcode, op, readnum, sximm8[7:0]};
  endfunction

  task automatic push_word(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_for_s(input int max_cycles);
    bit found;
    found = 1'b0;
    w = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (s) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("s_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_run();
    logic [15:0] snap;
    snap = ir_view();
    w = 1'b0;
    @(posedge clk); #1;
    check("s_single_cycle", s, 1'b0);
    check("ir_hold_run", ir_view(), snap);
    w = 1'b1;
    @(posedge clk); #1;
    w = 1'b0;
  endtask

  // FSM model: w low for 4 cycles after each s pulse, otherwise waiting.
  task automatic run_model(input int cycles, output int pulses, output logic [15:0] first_ir);
    int          hold;
    logic [15:0] snap;
    pulses   = 0;
    hold     = 0;
    first_ir = 16'hxxxx;
    snap     = 16'h0000;
    w = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (s) begin
        if (hold > 0) check("s_spacing", 32'd1, 32'd0);
        pulses++;
        if (pulses == 1) first_ir = ir_view();
        snap = ir_view();
        w    = 1'b0;
        hold = 4;
      end else if (hold > 0) begin
        check("run_ir_stable", ir_view(), snap);
        hold--;
        if (hold == 0) w = 1'b1;
      end
    end
    w = 1'b0;
  endtask

  initial begin
    int          pulses;
    logic [15:0] first_ir;

    words[0] = 16'hA001;
    words[1] = 16'hA122;
    words[2] = 16'hAA43;
    words[3] = 16'hB364;
    words[4] = 16'hA485;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    w        = 1'b0;
    nsel     = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_s", s, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_ir", ir_view(), 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD R2,R1,R0
    push_word(16'hA140);
    check("add_count", count, 3'd1);
    wait_for_s(4);
    check("add_s", s, 1'b1);
    check("add_opcode", opcode, 3'b101);
    check("add_op", op, 2'b00);
    check("add_aluop", ALUop, 2'b00);
    nsel = 3'b100; #1; check("add_rn", readnum, 3'd1);
    nsel = 3'b010; #1; check("add_rd", readnum, 3'd2);
    nsel = 3'b001; #1; check("add_rm", readnum, 3'd0);
    nsel = 3'b011; #1; check("add_nsel_bad", readnum, 3'd0);
    nsel = 3'b100; #1;
    finish_run();
    check("add_empty", count, 3'd0);

    // MOV R0,#-3
    push_word(16'hD0FD);
    wait_for_s(4);
    check("mov_opcode", opcode, 3'b110);
    check("mov_op", op, 2'b10);
    check("mov_sximm8", sximm8, 16'hFFFD);
    check("mov_sximm5", sximm5, 16'hFFFD);
    check("mov_shift", shift, 2'b11);
    check("mov_writenum", writenum, 3'd0);
    finish_run();

    // Full and ordering
    for (int i = 0; i < 4; i++) push_word(words[i]);
    check("full_in_ready", in_ready, 1'b0);
    check("full_count", count, 3'd4);
    in_valid = 1'b1;
    in_data  = words[4];
    repeat (2) @(posedge clk);
    #1;
    check("full_no_push", count, 3'd4);
    wait_for_s(4);
    check("order_0", ir_view(), words[0]);
    check("pop_count", count, 3'd3);
    check("pop_in_ready", in_ready, 1'b1);
    w = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fifth_pushed", count, 3'd4);
    w = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k < 5; k++) begin
      wait_for_s(4);
      check($sformatf("order_%0d", k), ir_view(), words[k]);
      finish_run();
    end
    check("drained", count, 3'd0);

    // Back-to-back with FSM model
    push_word(16'hA140);
    push_word(16'hD0FD);
    run_model(30, pulses, first_ir);
    check("b2b_pulses", pulses, 2);
    check("b2b_first", first_ir, 16'hA140);
    check("b2b_last", ir_view(), 16'hD0FD);
    check("b2b_empty", count, 3'd0);

    // Reset mid-ISSUE with three entries still buffered
    for (int i = 0; i < 4; i++) push_word(words[i]);
    wait_for_s(4);
    w = 1'b0;
    check("pre_rst_count", count, 3'd3);
    #3;
    reset = 1'b0;
    #1;
    check("arst_count", count, 3'd0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_s", s, 1'b0);
    check("arst_opcode", opcode, 3'd0);
    check("arst_sximm8", sximm8, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_count", count, 3'd0);

    // Illegal-instruction handling
    push_word(16'h0000);
    push_word(16'hA140);
    run_model(20, pulses, first_ir);
`ifdef ILLEGAL_DROP_EN
    check("ill_flag", illegal, 1'b1);
    check("ill_pulses", pulses, 1);
    check("ill_issued", first_ir, 16'hA140);
`else
    check("ill_flag", illegal, 1'b0);
    check("ill_pulses", pulses, 2);
    check("ill_issued", first_ir, 16'h0000);
`endif
    check("ill_empty", count, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_issue_queue.md
# instr_issue_queue

Instruction buffer, register and decoder sitting directly upstream of `stateMachine`. Accepts 16-bit instructions from a producer over a valid/ready handshake, holds them in a FIFO, and issues one at a time. An instruction issues by loading it into the instruction register and pulsing `s` while the FSM reports wait (`w`). Decodes the held instruction into the fields the FSM and datapath consume: `opcode`, `op`, register numbers selected by the FSM's `nsel`, `shift`, and sign-extended immediates.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `in_valid`  in  1  producer presents an instruction.
- `in_data`  in  16  instruction word.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `w`  in  1  FSM is in its wait state.
- `nsel`  in  3  one-hot register select from the FSM: 100=Rn, 010=Rd, 001=Rm.
- `s`  out  1  start pulse to the FSM.
- `opcode`  out  3  IR[15:13].
- `op`  out  2  IR[12:11].
- `ALUop`  out  2  IR[12:11].
- `shift`  out  2  IR[4:3].
- `readnum`  out  3  register number selected by `nsel`.
- `writenum`  out  3  same value as `readnum`.
- `sximm5`  out  16  IR[4:0] sign-extended.
- `sximm8`  out  16  IR[7:0] sign-extended.
- `count`  out  log2(DEPTH)+1  FIFO occupancy.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- Field layout: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm.
- `nsel` mux: 100→Rn, 010→Rd, 001→Rm, any other value→000. The mux is combinational from the IR.
- FIFO:
  - Push when `in_valid && in_ready`.
  - Pop only on the IDLE→ISSUE transition (and on illegal drops; see Configuration).
  - Simultaneous push and pop leaves `count` unchanged.
  - When full, `in_ready`=0 even in a pop cycle. No push-on-pop when full.
  - Pointers wrap modulo DEPTH.
- Issue FSM states and transitions:
  - IDLE: if `w`=1 and `count`>0, load IR from the FIFO head, pop, and go to ISSUE. Otherwise stay in IDLE and hold the IR.
  - ISSUE: `s`=1 for this cycle only. Always go to RUN on the next edge.
  - RUN: `s`=0 and the IR is held. Go to IDLE on the first cycle with `w`=1.
- `s` is a Moore output of state ISSUE. It is never asserted in any other state.
- The IR and all decoded outputs are stable from the ISSUE cycle until the next issue.
- Empty FIFO with `w`=1: stay in IDLE, `s`=0, IR unchanged.

## Timing
- Reset values: `s`=0, IR=16'h0000, so `opcode`/`op`/`ALUop`/`shift`=0, `readnum`/`writenum`=0, `sximm5`/`sximm8`=16'h0000. Also `count`=0, `in_ready`=1, `illegal`=0, FIFO empty, state IDLE.
- An instruction pushed at edge N reaches the FIFO head in cycle N+1. With `w`=1 it loads into the IR at edge N+1, and `s`=1 during cycle N+1..N+2. There is no bypass path.
- Decoded fields are valid in the same cycle `s` is high, so the FSM samples a consistent `opcode`/`op`.
- The FSM leaves wait on the edge that ends the ISSUE cycle, so `w`=0 in the first RUN cycle.
- Minimum spacing between `s` pulses is the FSM instruction length + 2 cycles (RUN exit, then IDLE).
- Reset asserted mid-RUN or mid-ISSUE immediately forces all reset values. Buffered instructions are discarded.

## Configuration
- `ILLEGAL_DROP_EN` defined:
  - Legal instructions are opcode 101 (any op), and opcode 110 with op 10 or op 00.
  - In IDLE with `w`=1, an illegal head entry is popped without loading the IR and without issue. `illegal` is set to 1 and held until reset. The FSM stays in IDLE and evaluates the next head on the next cycle.
- `ILLEGAL_DROP_EN` undefined:
  - Every entry issues.
  - `illegal` is tied to 0.

## Test plan
- Reset: drive `reset`=0 mid-stream with 3 entries buffered → `count`=0, `in_ready`=1, `s`=0, `opcode`=0, `sximm8`=16'h0000 immediately, without waiting for a clock edge.
- ADD R2,R1,R0: push 16'hA140 with `w`=1 → single-cycle `s`, `opcode`=101, `op`=00. `nsel`=100/010/001 → `readnum`=1/2/0.
- MOV R0,#-3: push 16'hD0FD → `opcode`=110, `op`=10, `sximm8`=16'hFFFD, `nsel`=100 → `writenum`=0. `sximm5` shows IR[4:0]=11101 sign-extended, giving 16'hFFFD.
- Full/order (DEPTH=4, `w`=0): push 5 words → `in_ready` drops after the 4th and `count`=4. The 5th is accepted only after the first issue. Issue order matches push order.
- Back-to-back: 2 entries buffered, bench FSM model holds `w`=0 for 4 cycles after each `s` → exactly two `s` pulses, and the IR is unchanged during each RUN.
- `ILLEGAL_DROP_EN`: push 16'h0000 then 16'hA140 → `illegal`=1, exactly one `s` pulse, `opcode`=101 during it.
